simon_seq_ctrl: RTL



---
 rtl/simon_pkg.sv | 22 ++
 rtl/simon_show_timer.sv | 38 +++
 rtl/simon_seq_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/simon_pkg.sv
// Shared state encoding and mode-LED patterns for the Simon sequence controller.
package simon_pkg;

    typedef enum logic [2:0] {
        ST_INPUT    = 3'd0,
        ST_PLAYBACK = 3'd1,
        ST_REPEAT   = 3'd2,
        ST_DONE     = 3'd3,
        ST_WIN      = 3'd4
    } state_t;

    localparam logic [2:0] LED_MODE_INPUT    = 3'b001;
    localparam logic [2:0] LED_MODE_PLAYBACK = 3'b010;
    localparam logic [2:0] LED_MODE_REPEAT   = 3'b100;
    localparam logic [2:0] LED_MODE_DONE     = 3'b111;
    localparam logic [2:0] LED_MODE_WIN      = 3'b101;

    function automatic int maxInt(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/simon_show_timer.sv
// Tick counter shared by playback, game-over replay, the win blink and the guess timeout.
module simon_show_timer #(
    parameter int TW            = 4,
    parameter int ON_TICKS      = 4,
    parameter int GAP_TICKS     = 2,
    parameter int TIMEOUT_TICKS = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_count,
    output logic o_on,
    output logic o_last,
    output logic o_expired,
    output logic o_blink
);

    localparam logic [TW-1:0] ON_LIM  = TW'(ON_TICKS);
    localparam logic [TW-1:0] LAST    = TW'(ON_TICKS + GAP_TICKS - 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_TICKS - 1);

    logic [TW-1:0] r_tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_tick <= '0;
        else if (i_clear)
            r_tick <= '0;
        else if (i_count)
            r_tick <= r_tick + TW'(1);
    end

    assign o_on      = (r_tick < ON_LIM);
    assign o_last    = (r_tick == LAST);
    assign o_expired = (r_tick == TO_LAST);
    assign o_blink   = r_tick[TW-1];

endmodule

// File: rtl/simon_seq_ctrl.sv
// Simon game sequencer: owns pattern length, index and display timing.
// Optional guess timeout in REPEAT is enabled by defining SIMON_TIMEOUT_EN.
module simon_seq_ctrl
    import simon_pkg::*;
#(
    parameter int DEPTH         = 64,
    parameter int ON_TICKS      = 4,
    parameter int GAP_TICKS     = 2,
    parameter int TIMEOUT_TICKS = 1024,
    localparam int AW           = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          submit,
    input  logic          legal,
    input  logic          guess_valid,
    input  logic          right_guess,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic          disp_sel,
    output logic          disp_en,
    output logic [AW:0]   level,
    output logic [2:0]    mode_leds
);

    localparam int TW = $clog2(maxInt(ON_TICKS + GAP_TICKS, TIMEOUT_TICKS) + 1);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
`ifdef SIMON_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    state_t        r_state;
    logic [AW:0]   r_ns;
    logic [AW-1:0] r_i;

    state_t        w_state_nx;
    logic [AW:0]   w_ns_nx;
    logic [AW-1:0] w_i_nx;
    logic          w_tclr;
    logic          w_tinc;
    logic          w_on;
    logic          w_last;
    logic          w_expired;
    logic          w_blink;
    logic          w_last_idx;

    simon_show_timer #(
        .TW            (TW),
        .ON_TICKS      (ON_TICKS),
        .GAP_TICKS     (GAP_TICKS),
        .TIMEOUT_TICKS (TIMEOUT_TICKS)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (w_tclr),
        .i_count   (w_tinc),
        .o_on      (w_on),
        .o_last    (w_last),
        .o_expired (w_expired),
        .o_blink   (w_blink)
    );

    assign w_last_idx = ({1'b0, r_i} == (r_ns - (AW+1)'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_INPUT;
            r_ns    <= '0;
            r_i     <= '0;
        end else begin
            r_state <= w_state_nx;
            r_ns    <= w_ns_nx;
            r_i     <= w_i_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_ns_nx    = r_ns;
        w_i_nx     = r_i;
        w_tclr     = 1'b0;
        w_tinc     = 1'b0;
        case (r_state)
            ST_INPUT: begin
                if (submit && legal) begin
                    w_ns_nx    = r_ns + (AW+1)'(1);
                    w_i_nx     = '0;
                    w_tclr     = 1'b1;
                    w_state_nx = ST_PLAYBACK;
                end
            end
            ST_PLAYBACK, ST_DONE: begin
                w_tinc = 1'b1;
                if (w_last) begin
                    w_tclr = 1'b1;
                    if (w_last_idx) begin
                        w_i_nx = '0;
                        if (r_state == ST_PLAYBACK)
                            w_state_nx = ST_REPEAT;
                    end else begin
                        w_i_nx = r_i + AW'(1);
                    end
                end
            end
            ST_REPEAT: begin
                w_tinc = TIMEOUT_EN;
                if (guess_valid) begin
                    w_tclr = 1'b1;
                    if (!right_guess) begin
                        w_i_nx     = '0;
                        w_state_nx = ST_DONE;
                    end else if (!w_last_idx) begin
                        w_i_nx = r_i + AW'(1);
                    end else if (r_ns == FULL) begin
                        w_state_nx = ST_WIN;
                    end else begin
                        w_i_nx     = '0;
                        w_state_nx = ST_INPUT;
                    end
                end else if (TIMEOUT_EN && w_expired) begin
                    // A silent player is treated exactly like a wrong guess.
                    w_tclr     = 1'b1;
                    w_i_nx     = '0;
                    w_state_nx = ST_DONE;
                end
            end
            ST_WIN: begin
                w_tinc = 1'b1;
            end
            default: begin
                w_state_nx = ST_INPUT;
            end
        endcase
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = r_i;
        disp_sel  = 1'b0;
        disp_en   = 1'b1;
        mode_leds = LED_MODE_INPUT;
        case (r_state)
            ST_INPUT: begin
                mem_we   = submit & legal;
                mem_addr = r_ns[AW-1:0];
            end
            ST_PLAYBACK: begin
                mode_leds = LED_MODE_PLAYBACK;
                disp_sel  = 1'b1;
                disp_en   = w_on;
            end
            ST_REPEAT: begin
                mode_leds = LED_MODE_REPEAT;
            end
            ST_DONE: begin
                mode_leds = LED_MODE_DONE;
                disp_sel  = 1'b1;
                disp_en   = w_on;
            end
            ST_WIN: begin
                mode_leds = LED_MODE_WIN;
                disp_en   = w_blink;
            end
            default: begin
                mode_leds = LED_MODE_INPUT;
            end
        endcase
    end

    assign level = r_ns;

endmodule
